// File: rtl/sbox_share_sched.sv
// Four shared AES S-box lanes, time-multiplexed between a column-serial SubBytes
// requester and a single-cycle SubWord requester, with round-robin tie breaking.

module SBox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

    // Multiplicative inverse as din^254 (zero maps to zero), then the affine map.
    always_comb begin
        x2   = gmul(din, din);
        x3   = gmul(x2, din);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        x252 = gmul(x240, x12);
        inv  = gmul(x252, x2);
        dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

module sbox_share_sched #(
    parameter bit KEY_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [0:3][0:3][7:0]  st_in,
    output logic [0:3][0:3][7:0]  st_out,
    output logic                  st_done,
    input  logic                  key_valid,
    output logic                  key_ready,
    input  logic [31:0]           key_in,
    output logic [31:0]           key_out,
    output logic                  key_done,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ST_BUSY, KEY_BUSY} state_t;

    localparam logic GRANT_ST  = 1'b0;
    localparam logic GRANT_KEY = 1'b1;

    state_t                state, next_state;
    logic [1:0]            col;
    logic                  last_grant;
    logic                  grant_key;
    logic [0:3][0:3][7:0]  st_buf;
    logic [31:0]           key_buf;
    logic [3:0][7:0]       lane_in;
    logic [3:0][7:0]       lane_out;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        SBox u_lane (.din(lane_in[k]), .dout(lane_out[k]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (st_valid && st_ready)        next_state = ST_BUSY;
                else if (key_valid && key_ready) next_state = KEY_BUSY;
            end
            ST_BUSY:  if (col == 2'd3) next_state = IDLE;
            KEY_BUSY: next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Key wins a tie only when the state side was granted last.
    always_comb begin
        grant_key = key_valid && (!st_valid || last_grant == GRANT_ST);
        st_ready  = (state == IDLE) && st_valid && !grant_key;
        key_ready = (state == IDLE) && key_valid && grant_key;
        busy      = (state != IDLE);
        for (int k = 0; k < 4; k++) begin
            lane_in[k] = 8'h00;
            case (state)
                ST_BUSY:  lane_in[k] = st_buf[k][col];
                KEY_BUSY: lane_in[k] = key_buf[8*k +: 8];
                default:  lane_in[k] = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_buf     <= '0;
            key_buf    <= '0;
            st_out     <= '0;
            key_out    <= '0;
            st_done    <= 1'b0;
            key_done   <= 1'b0;
            col        <= 2'd0;
            last_grant <= KEY_FIRST ? GRANT_ST : GRANT_KEY;
        end else begin
            st_done  <= 1'b0;
            key_done <= 1'b0;
            if (st_valid && st_ready) begin
                st_buf     <= st_in;
                col        <= 2'd0;
                last_grant <= GRANT_ST;
            end
            if (key_valid && key_ready) begin
                key_buf    <= key_in;
                last_grant <= GRANT_KEY;
            end
            case (state)
                ST_BUSY: begin
                    for (int r = 0; r < 4; r++) st_out[r][col] <= lane_out[r];
                    col <= col + 2'd1;
                    if (col == 2'd3) st_done <= 1'b1;
                end
                KEY_BUSY: begin
                    key_out  <= lane_out;
                    key_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_share_sched.sv
// Randomized and directed bench for sbox_share_sched against a job-level
// reference model using a generator-built S-box table.

module tb_sbox_share_sched;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  st_valid = 1'b0;
    logic                  st_ready;
    logic [0:3][0:3][7:0]  st_in = '0;
    logic [0:3][0:3][7:0]  st_out;
    logic                  st_done;
    logic                  key_valid = 1'b0;
    logic                  key_ready;
    logic [31:0]           key_in = '0;
    logic [31:0]           key_out;
    logic                  key_done;
    logic                  busy;

    sbox_share_sched #(.KEY_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_in(st_in),
        .st_out(st_out), .st_done(st_done),
        .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
        .key_out(key_out), .key_done(key_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] sboxTab [256];

    // Reference model: remaining job cycles, tie pointer (1 = key granted last).
    int                    mRem;
    bit                    mKindKey;
    bit                    mLast;
    logic [0:3][0:3][7:0]  mStBuf, expSt;
    logic [31:0]           mKeyBuf, expKey;
    bit                    expStDone, expKeyDone;

    int grantKind[$];
    int grantCyc[$];
    int lastStDoneCyc;
    int lastKeyDoneCyc;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s got %h want %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic buildTable();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sboxTab[p] = x ^ 8'h63;
        end
        sboxTab[0] = 8'h63;
    endtask

    task automatic modelReset();
        mRem       = 0;
        mKindKey   = 1'b0;
        mLast      = 1'b0;
        mStBuf     = '0;
        mKeyBuf    = '0;
        expSt      = '0;
        expKey     = '0;
        expStDone  = 1'b0;
        expKeyDone = 1'b0;
    endtask

    function automatic bit modelStateWins();
        return (mRem == 0) && st_valid && (!key_valid || mLast);
    endfunction

    function automatic bit modelKeyWins();
        return (mRem == 0) && key_valid && !modelStateWins();
    endfunction

    task automatic modelStep();
        bit accSt, accKey;
        int c;
        accSt      = modelStateWins();
        accKey     = modelKeyWins();
        expStDone  = 1'b0;
        expKeyDone = 1'b0;
        if (mRem > 0) begin
            if (!mKindKey) begin
                c = 4 - mRem;
                for (int r = 0; r < 4; r++) expSt[r][c] = sboxTab[mStBuf[r][c]];
                if (mRem == 1) expStDone = 1'b1;
            end else begin
                for (int k = 0; k < 4; k++) expKey[8*k +: 8] = sboxTab[mKeyBuf[8*k +: 8]];
                expKeyDone = 1'b1;
            end
            mRem--;
        end
        if (accSt) begin
            mStBuf = st_in; mRem = 4; mKindKey = 1'b0; mLast = 1'b0;
        end else if (accKey) begin
            mKeyBuf = key_in; mRem = 1; mKindKey = 1'b1; mLast = 1'b1;
        end
    endtask

    task automatic compareAll();
        checkOutput("st_ready", st_ready, modelStateWins());
        checkOutput("key_ready", key_ready, modelKeyWins());
        checkOutput("busy", busy, mRem != 0);
        checkOutput("st_done", st_done, expStDone);
        checkOutput("key_done", key_done, expKeyDone);
        checkOutput("done_excl", st_done & key_done, 1'b0);
        checkOutput("st_out", st_out, expSt);
        checkOutput("key_out", key_out, expKey);
        if (st_done)  lastStDoneCyc  = cyc;
        if (key_done) lastKeyDoneCyc = cyc;
    endtask

    // One clock: note handshakes just before the edge, advance the model, check at negedge.
    task automatic cycle();
        bit stFire, keyFire;
        #1;
        stFire  = st_ready && st_valid;
        keyFire = key_ready && key_valid;
        @(posedge clk);
        modelStep();
        cyc++;
        if (stFire)  begin grantKind.push_back(0); grantCyc.push_back(cyc); end
        if (keyFire) begin grantKind.push_back(1); grantCyc.push_back(cyc); end
        @(negedge clk);
        compareAll();
    endtask

    task automatic doReset();
        rst = 1'b1;
        modelReset();
        #2;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_st_out", st_out, 128'h0);
        checkOutput("rst_key_out", key_out, 32'h0);
        checkOutput("rst_st_done", st_done, 1'b0);
        checkOutput("rst_key_done", key_done, 1'b0);
        #1;
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input bit sv, input logic [127:0] sd, input bit kv, input logic [31:0] kd);
        st_valid  = sv;
        st_in     = sd;
        key_valid = kv;
        key_in    = kd;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] FIPS_IN  = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;

    initial begin
        int acc;
        bit seen;
        buildTable();
        checkOutput("tab_00", sboxTab[8'h00], 8'h63);
        checkOutput("tab_53", sboxTab[8'h53], 8'hed);

        rst = 1'b1;
        @(negedge clk);
        doReset();

        // Tie: both valids held high from reset.
        grantKind.delete(); grantCyc.delete();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, rand128(), 1'b1, $urandom);
            cycle();
        end
        checkOutput("tie_count", grantKind.size() >= 4, 1'b1);
        if (grantKind.size() >= 4) begin
            checkOutput("tie_g0", grantKind[0], 1);
            checkOutput("tie_g1", grantKind[1], 0);
            checkOutput("tie_g2", grantKind[2], 1);
            checkOutput("tie_g3", grantKind[3], 0);
            checkOutput("tie_gap0", grantCyc[1] - grantCyc[0], 2);
            checkOutput("tie_gap1", grantCyc[2] - grantCyc[1], 5);
            checkOutput("tie_gap2", grantCyc[3] - grantCyc[2], 2);
        end
        applyStimulus(1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 6; i++) cycle();

        doReset();

        // Single state job; st_in changes right after the accept edge.
        applyStimulus(1'b1, FIPS_IN, 1'b0, '0);
        cycle();
        acc = cyc;
        applyStimulus(1'b0, rand128(), 1'b0, '0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            if (i == 0) st_in = rand128();
            if (st_done) seen = 1'b1;
        end
        checkOutput("st_done_seen", seen, 1'b1);
        checkOutput("st_latency", lastStDoneCyc - acc, 4);
        checkOutput("st_fips", st_out, FIPS_OUT);

        // Single key job.
        applyStimulus(1'b0, '0, 1'b1, 32'h09cf4f3c);
        cycle();
        acc = cyc;
        applyStimulus(1'b0, '0, 1'b0, $urandom);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            cycle();
            if (key_done) seen = 1'b1;
        end
        checkOutput("key_done_seen", seen, 1'b1);
        checkOutput("key_latency", lastKeyDoneCyc - acc, 1);
        checkOutput("key_fips", key_out, 32'h018a84eb);
        cycle();

        // Key request arriving at E2 of a state job.
        grantKind.delete(); grantCyc.delete();
        applyStimulus(1'b1, rand128(), 1'b0, '0);
        cycle();
        st_valid = 1'b0;
        cycle();
        cycle();
        key_valid = 1'b1;
        key_in    = $urandom;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            if (grantKind.size() >= 2) begin
                seen = 1'b1;
                key_valid = 1'b0;
            end
        end
        key_valid = 1'b0;
        checkOutput("busy_req_seen", seen, 1'b1);
        if (grantKind.size() >= 2) begin
            checkOutput("busy_req_kind", grantKind[1], 1);
            checkOutput("busy_req_gap", grantCyc[1] - grantCyc[0], 5);
        end
        for (int i = 0; i < 3; i++) cycle();

        // Reset at E2 of a state job, then reissue.
        applyStimulus(1'b1, rand128(), 1'b0, '0);
        cycle();
        st_valid = 1'b0;
        cycle();
        cycle();
        doReset();
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (st_done) seen = 1'b1;
        end
        checkOutput("abort_no_done", seen, 1'b0);
        applyStimulus(1'b1, FIPS_IN, 1'b0, '0);
        cycle();
        st_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            if (st_done) seen = 1'b1;
        end
        checkOutput("reissue_seen", seen, 1'b1);
        checkOutput("reissue_fips", st_out, FIPS_OUT);

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 79) == 0) doReset();
            applyStimulus($urandom_range(0, 2) != 0, rand128(), $urandom_range(0, 1) == 1, $urandom);
            cycle();
        end
        applyStimulus(1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 6; i++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
